// File: rtl/fifo_sync_param_pkg.sv
// rtl/fifo_sync_param_pkg.sv - shared width helpers and flag struct for the sync FIFO family
package fifo_sync_param_pkg;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra pointer bit separates the full and empty cases when addresses match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - producer/consumer bundle of the single-clock FIFO
interface fifo_sync_param_if
    import fifo_sync_param_pkg::*;
#(
    parameter int W_DATA = 8,
    parameter int DEPTH  = 16
);
    localparam int PTR_W = ptr_width(DEPTH);

    logic              push;
    logic [W_DATA-1:0] data_in;
    logic              pop;
    logic [W_DATA-1:0] data_out;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [PTR_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    modport master (
        output push, data_in, pop, clr_err,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, data_in, pop, clr_err,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_sync_ram.sv
// rtl/fifo_sync_ram.sv - simple dual-port RAM, sync write, async or registered read
module fifo_sync_ram
    import fifo_sync_param_pkg::*;
#(
    parameter int W_DATA   = 8,
    parameter int DEPTH    = 16,
    parameter int ASYNC_RD = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [addr_width(DEPTH)-1:0] waddr,
    input  logic [W_DATA-1:0]            wdata,
    input  logic                         re,
    input  logic [addr_width(DEPTH)-1:0] raddr,
    output logic [W_DATA-1:0]            rdata
);
    logic [W_DATA-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    generate
        if (ASYNC_RD != 0) begin : g_async
            logic unused_ok;
            assign unused_ok = &{1'b0, rst, re};
            assign rdata = mem_q[raddr];
        end else begin : g_sync
            // Only the output register is reset; array contents stay unknown.
            logic [W_DATA-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem_q[raddr];
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock parametrised FIFO with thresholds, count and sticky errors
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int W_DATA    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic                clk,
    input  logic                rst,
    fifo_sync_param_if.slave    bus
);
    localparam int ADDR_W = addr_width(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);

    typedef logic [W_DATA-1:0] sdata_t;
    typedef logic [PTR_W-1:0]  sptr_t;
    typedef logic [PTR_W-1:0]  scount_t;

    sptr_t       wptr_q, wptr_d;
    sptr_t       rptr_q, rptr_d;
    scount_t     count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        wr_acc, rd_acc;
    fifo_flags_t flags;
    sdata_t      ram_rdata;

    // Flags decode from the registered count, so they follow the accepting edge directly.
    always_comb begin
        flags.full         = (count_q == scount_t'(DEPTH));
        flags.empty        = (count_q == '0);
        flags.almost_full  = (count_q >= scount_t'(AF_THRESH));
        flags.almost_empty = (count_q <= scount_t'(AE_THRESH));
    end

    always_comb begin
        wr_acc      = bus.push & ~flags.full;
        rd_acc      = bus.pop & ~flags.empty;
        wptr_d      = wptr_q + sptr_t'(wr_acc);
        rptr_d      = rptr_q + sptr_t'(rd_acc);
        count_d     = count_q + scount_t'(wr_acc) - scount_t'(rd_acc);
        overflow_d  = (bus.push & flags.full) | (overflow_q & ~bus.clr_err);
        underflow_d = (bus.pop & flags.empty) | (underflow_q & ~bus.clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_sync_ram #(
        .W_DATA   (W_DATA),
        .DEPTH    (DEPTH),
        .ASYNC_RD (FWFT)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~rst),
        .waddr (wptr_q[ADDR_W-1:0]),
        .wdata (bus.data_in),
        .re    (rd_acc & ~rst),
        .raddr (rptr_q[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT == 0) begin : g_reg_rd
            logic rd_valid_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                end
            end
            assign bus.rd_valid = rd_valid_q;
        end else begin : g_fwft_rd
            assign bus.rd_valid = ~flags.empty;
        end
    endgenerate

    assign bus.data_out     = ram_rdata;
    assign bus.full         = flags.full;
    assign bus.empty        = flags.empty;
    assign bus.almost_full  = flags.almost_full;
    assign bus.almost_empty = flags.almost_empty;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed vector bench for registered-read and FWFT FIFO builds
module tb_fifo_sync_param;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.W_DATA(8), .DEPTH(8)) bus0 ();
    fifo_sync_param_if #(.W_DATA(8), .DEPTH(8)) bus1 ();

    fifo_sync_param #(
        .W_DATA(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)
    ) u_reg (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    fifo_sync_param #(
        .W_DATA(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)
    ) u_fwft (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] din;
        int         cnt;
        logic       ovf;
        logic       unf;
        logic       rdv;
        logic       chk;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];
    int   model[$];

    function automatic vec_t mk(logic push, logic pop, logic clr, logic [7:0] din, int cnt,
                                logic ovf, logic unf, logic rdv, logic chk, logic [7:0] dout);
        vec_t v;
        v.push = push; v.pop = pop; v.clr = clr; v.din = din; v.cnt = cnt;
        v.ovf = ovf; v.unf = unf; v.rdv = rdv; v.chk = chk; v.dout = dout;
        return v;
    endfunction

    // {count, full, empty, almost_full, almost_empty, overflow, underflow, rd_valid}
    function automatic logic [10:0] st(int cnt, logic ovf, logic unf, logic rdv);
        logic [3:0] c;
        c = cnt[3:0];
        return {c, cnt == 8, cnt == 0, cnt >= 6, cnt <= 1, ovf, unf, rdv};
    endfunction

    function automatic logic [10:0] act0();
        return {bus0.count, bus0.full, bus0.empty, bus0.almost_full, bus0.almost_empty,
                bus0.overflow, bus0.underflow, bus0.rd_valid};
    endfunction

    function automatic logic [10:0] act1();
        return {bus1.count, bus1.full, bus1.empty, bus1.almost_full, bus1.almost_empty,
                bus1.overflow, bus1.underflow, bus1.rd_valid};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step0(input logic push, input logic pop, input logic clr, input logic [7:0] din);
        bus0.push = push; bus0.pop = pop; bus0.clr_err = clr; bus0.data_in = din;
        @(posedge clk);
        #1;
        bus0.push = 1'b0; bus0.pop = 1'b0; bus0.clr_err = 1'b0;
    endtask

    task automatic step1(input logic push, input logic pop, input logic [7:0] din);
        bus1.push = push; bus1.pop = pop; bus1.clr_err = 1'b0; bus1.data_in = din;
        @(posedge clk);
        #1;
        bus1.push = 1'b0; bus1.pop = 1'b0;
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        step0(1'b0, 1'b0, 1'b0, 8'h00);
        rst0 = 1'b0;
    endtask

    initial begin
        bus0.push = 1'b0; bus0.pop = 1'b0; bus0.clr_err = 1'b0; bus0.data_in = 8'h00;
        bus1.push = 1'b0; bus1.pop = 1'b0; bus1.clr_err = 1'b0; bus1.data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        check("reset_status", 32'(act0()), 32'(st(0, 1'b0, 1'b0, 1'b0)));
        check("reset_dout", 32'(bus0.data_out), 32'h0);
        check("fwft_reset_status", 32'(act1()), 32'(st(0, 1'b0, 1'b0, 1'b0)));

        // Fill, overflow, drain in order, underflow and error clearing.
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1, 0, 0, 8'(8'h10 + k), k, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 0, 8'hFF, 8, 1, 0, 0, 0, 8'h00));
        for (int j = 1; j <= 8; j++)
            vecs.push_back(mk(0, 1, 0, 8'h00, 8 - j, 1, 0, 1, 1, 8'(8'h10 + j)));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'h18));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, 1, 0, 1, 8'h18));
        vecs.push_back(mk(0, 1, 1, 8'h00, 0, 0, 1, 0, 1, 8'h18));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h18));

        foreach (vecs[i]) begin
            step0(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
            check($sformatf("vec%0d_status", i), 32'(act0()),
                  32'(st(vecs[i].cnt, vecs[i].ovf, vecs[i].unf, vecs[i].rdv)));
            if (vecs[i].chk)
                check($sformatf("vec%0d_dout", i), 32'(bus0.data_out), 32'(vecs[i].dout));
        end

        // Steady push+pop at count 3 across several pointer wraps.
        reset0();
        for (int c = 0; c < 3; c++) begin
            step0(1'b1, 1'b0, 1'b0, 8'(c));
            model.push_back(c);
        end
        for (int c = 3; c < 43; c++) begin
            int exp_d;
            step0(1'b1, 1'b1, 1'b0, 8'(c));
            model.push_back(c);
            exp_d = model.pop_front();
            check($sformatf("stream%0d_status", c), 32'(act0()), 32'(st(3, 1'b0, 1'b0, 1'b1)));
            check($sformatf("stream%0d_dout", c), 32'(bus0.data_out), 32'(exp_d));
        end

        // Push and pop together while full: push rejected, pop served.
        reset0();
        for (int k = 1; k <= 8; k++)
            step0(1'b1, 1'b0, 1'b0, 8'(8'h20 + k));
        step0(1'b1, 1'b1, 1'b0, 8'h99);
        check("full_pushpop_status", 32'(act0()), 32'(st(7, 1'b1, 1'b0, 1'b1)));
        check("full_pushpop_dout", 32'(bus0.data_out), 32'h21);

        // Reset with a concurrent push discards everything, including that word.
        reset0();
        for (int k = 1; k <= 5; k++)
            step0(1'b1, 1'b0, 1'b0, 8'(8'h30 + k));
        check("pre_rst_count5", 32'(act0()), 32'(st(5, 1'b0, 1'b0, 1'b0)));
        rst0 = 1'b1;
        step0(1'b1, 1'b0, 1'b0, 8'hEE);
        rst0 = 1'b0;
        check("rst_push_status", 32'(act0()), 32'(st(0, 1'b0, 1'b0, 1'b0)));
        check("rst_push_dout", 32'(bus0.data_out), 32'h0);
        step0(1'b1, 1'b0, 1'b0, 8'h44);
        step0(1'b0, 1'b1, 1'b0, 8'h00);
        check("post_rst_read", 32'(bus0.data_out), 32'h44);
        step0(1'b0, 1'b1, 1'b0, 8'h00);
        check("post_rst_empty_status", 32'(act0()), 32'(st(0, 1'b0, 1'b1, 1'b0)));
        check("post_rst_empty_dout", 32'(bus0.data_out), 32'h44);

        // First-word-fall-through build.
        step1(1'b1, 1'b0, 8'hA5);
        check("fwft_push_status", 32'(act1()), 32'(st(1, 1'b0, 1'b0, 1'b1)));
        check("fwft_push_dout", 32'(bus1.data_out), 32'hA5);
        step1(1'b0, 1'b0, 8'h00);
        check("fwft_hold_dout", 32'(bus1.data_out), 32'hA5);
        step1(1'b0, 1'b1, 8'h00);
        check("fwft_pop_status", 32'(act1()), 32'(st(0, 1'b0, 1'b0, 1'b0)));
        step1(1'b1, 1'b0, 8'hB1);
        step1(1'b1, 1'b0, 8'hB2);
        check("fwft_two_status", 32'(act1()), 32'(st(2, 1'b0, 1'b0, 1'b1)));
        check("fwft_two_dout", 32'(bus1.data_out), 32'hB1);
        step1(1'b0, 1'b1, 8'h00);
        check("fwft_next_status", 32'(act1()), 32'(st(1, 1'b0, 1'b0, 1'b1)));
        check("fwft_next_dout", 32'(bus1.data_out), 32'hB2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
